// File: rtl/nibble_serial_add16.sv
// Nibble-serial W-bit adder/subtractor: one 4-bit ripple-carry stage is reused
// LSB-first for W/4 cycles, with a valid/ready handshake on each side.

module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];
endmodule

module nibble_serial_add16 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf
);
  localparam int N  = W / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  logic [W-1:0]  sum_reg, sum_next;
  logic          carry_reg, carry_next;
  logic          c_out_reg, c_out_next;
  logic          ovf_reg, ovf_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [3:0]    nib_sum;
  logic          nib_cout;

  nibble_add4 u_add4 (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry_reg),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      c_out_reg <= c_out_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    c_out_next = c_out_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so invert B once here and seed the carry.
          a_next     = a;
          b_next     = sub ? ~b : b;
          carry_next = sub ? 1'b1 : c_in;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Result fills from the top so the first nibble ends up at bit 0.
        sum_next   = (sum_reg >> 4) | (W'(nib_sum) << (W - 4));
        a_next     = a_reg >> 4;
        b_next     = b_reg >> 4;
        carry_next = nib_cout;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1)) begin
          ovf_next   = (a_reg[3] == b_reg[3]) && (nib_sum[3] != a_reg[3]);
          c_out_next = nib_cout;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_add16.sv
// Directed bench for nibble_serial_add16: a W=16 instance plus a W=4 instance.

module tb_nibble_serial_add16;
  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, c_in4, sub4, out_valid4, out_ready4, c_out4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int checks = 0;
  int errors = 0;

  nibble_serial_add16 #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  nibble_serial_add16 #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one operation on the W=16 instance and report result and latency.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, output logic [15:0] s, output logic co,
                        output logic ov, output int lat);
    @(negedge clk);
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum; co = c_out; ov = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b, expected 1 0 0000 0 0",
               in_ready, out_valid, sum, c_out, ovf);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_valid: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    $display("test_reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, sum);
  endtask

  task automatic test_add;
    logic [15:0] va[3], vb[3], es[3];
    logic        ec[3], eo[3];
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    va = '{16'h1234, 16'hFFFF, 16'h7FFF};
    vb = '{16'h4321, 16'h0001, 16'h0001};
    es = '{16'h5555, 16'h0000, 16'h8000};
    ec = '{1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, 1'b0, s, co, ov, lat);
      checks++;
      if (s !== es[i] || co !== ec[i] || ov !== eo[i] || lat != 4) begin
        errors++;
        $display("FAIL add_%0d: sum=%h c_out=%b ovf=%b lat=%0d, expected %h %b %b 4",
                 i, s, co, ov, lat, es[i], ec[i], eo[i]);
      end
      $display("test_add: %h + %h -> sum=%h c_out=%b ovf=%b lat=%0d", va[i], vb[i], s, co, ov, lat);
    end
  endtask

  task automatic test_sub;
    logic [15:0] va[2], vb[2], es[2];
    logic        ec[2], eo[2];
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    va = '{16'h0005, 16'h8000};
    vb = '{16'h0007, 16'h0001};
    es = '{16'hFFFE, 16'h7FFF};
    ec = '{1'b0, 1'b1};
    eo = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], 1'b1, 1'b1, s, co, ov, lat);
      checks++;
      if (s !== es[i] || co !== ec[i] || ov !== eo[i] || lat != 4) begin
        errors++;
        $display("FAIL sub_%0d: sum=%h c_out=%b ovf=%b lat=%0d, expected %h %b %b 4",
                 i, s, co, ov, lat, es[i], ec[i], eo[i]);
      end
      $display("test_sub: %h - %h -> sum=%h c_out=%b ovf=%b lat=%0d", va[i], vb[i], s, co, ov, lat);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    int          busy_bad;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    // Present a different operand while busy; it must be refused.
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
    busy_bad = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (busy_bad != 0 || lat != 4) begin
      errors++;
      $display("FAIL bp_run_ready: ready-high cycles=%0d lat=%0d, expected 0 4", busy_bad, lat);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3333 || c_out !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b sum=%h c_out=%b ovf=%b, expected 1 0 3333 0 0",
                 i, out_valid, in_ready, sum, c_out, ovf);
      end
      $display("test_backpressure: hold %0d sum=%h out_valid=%b", i, sum, out_valid);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h3333) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b sum=%h, expected 0 1 3333", out_valid, in_ready, sum);
    end
    run_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL bp_next_op: sum=%h c_out=%b ovf=%b lat=%0d, expected 0000 1 0 4", s, co, ov, lat);
    end
    $display("test_backpressure: next op sum=%h c_out=%b ovf=%b", s, co, ov);
  endtask

  task automatic test_abort;
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    int          seen;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b sum=%h c_out=%b, expected 1 0 0000 0",
               in_ready, out_valid, sum, c_out);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: out_valid high cycles=%0d, expected 0", seen);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 16'h1001 || co !== 1'b0 || ov !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL abort_next_op: sum=%h c_out=%b ovf=%b lat=%0d, expected 1001 0 0 4", s, co, ov, lat);
    end
    $display("test_abort: after abort sum=%h c_out=%b ovf=%b", s, co, ov);
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if (s !== 16'h0003 || co !== 1'b0 || ov !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL b2b_first: sum=%h c_out=%b ovf=%b lat=%0d, expected 0003 0 0 4", s, co, ov, lat);
    end
    $display("test_back_to_back: first sum=%h", s);
    run_op(16'h1000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if (s !== 16'h0FFF || co !== 1'b1 || ov !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL b2b_second: sum=%h c_out=%b ovf=%b lat=%0d, expected 0FFF 1 0 4", s, co, ov, lat);
    end
    $display("test_back_to_back: second sum=%h c_out=%b", s, co);
  endtask

  task automatic test_w4;
    logic [3:0] va[3], vb[3], es[3];
    logic       vc[3], vs[3], ec[3], eo[3];
    int         lat;
    va = '{4'h9, 4'h3, 4'h7};
    vb = '{4'h8, 4'h5, 4'h1};
    vc = '{1'b1, 1'b0, 1'b0};
    vs = '{1'b0, 1'b1, 1'b0};
    es = '{4'h2, 4'hE, 4'h8};
    ec = '{1'b1, 1'b0, 1'b0};
    eo = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a4 = va[i]; b4 = vb[i]; c_in4 = vc[i]; sub4 = vs[i]; in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (sum4 !== es[i] || c_out4 !== ec[i] || ovf4 !== eo[i] || lat != 1) begin
        errors++;
        $display("FAIL w4_%0d: sum=%h c_out=%b ovf=%b lat=%0d, expected %h %b %b 1",
                 i, sum4, c_out4, ovf4, lat, es[i], ec[i], eo[i]);
      end
      $display("test_w4: a=%h b=%h sub=%b -> sum=%h c_out=%b ovf=%b lat=%0d",
               va[i], vb[i], vs[i], sum4, c_out4, ovf4, lat);
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0; sub4 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add16.md
Name: nibble_serial_add16

Overview:
- Sequencer that wraps the team's 4-bit ripple-carry adder stage and performs W-bit add/subtract one nibble per cycle.
- It latches W-bit operands through a valid/ready input handshake and feeds nibbles LSB-first into one instance of the 4-bit adder.
- It chains the carry through a register and assembles the W-bit result with carry and signed overflow.
- Sits between operand producers and any result consumer; trades latency for a single 4-bit adder instance.

Parameters:
- W, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. N = W/4 nibble cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- c_in  input  1  carry-in for add mode; ignored when sub=1
- sub  input  1  0 = A+B+c_in, 1 = A-B (A + ~B + 1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result
- c_out  output  1  final carry-out; in sub mode 1 = no borrow
- ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low: sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - latch a_reg=a.
    - latch b_reg = sub ? ~b : b.
    - carry_reg = sub ? 1 : c_in.
    - cnt=0.
    - go to RUN.
  - RUN: in_ready=0. Each cycle the 4-bit adder receives a_reg[3:0], b_reg[3:0], carry_reg. At the edge:
    - sum_reg <= {nib_sum, sum_reg[W-1:4]}.
    - a_reg and b_reg shift right by 4.
    - carry_reg <= nib_cout.
    - cnt++.
    - When cnt == N-1:
      - ovf <= (a_reg[3]==b_reg[3]) && (nib_sum[3]!=a_reg[3]), using post-inversion b.
      - c_out <= nib_cout.
      - go to DONE.
  - DONE: out_valid=1; sum, c_out and ovf are stable. On an edge with out_ready=1, go to IDLE (out_valid=0 next cycle). While out_ready=0, hold all outputs indefinitely.
- Latency:
  - Operands accepted at edge k give out_valid=1 after edge k+N (N=4 for W=16).
  - Minimum issue interval is N+2 cycles: no accept in the same cycle as the DONE handshake.
- sum, c_out and ovf hold their last value after leaving DONE until the next result overwrites them. Consumers must only sample when out_valid=1.
- in_valid while not IDLE is ignored; in_ready=0 outside IDLE. Operand inputs are sampled only at the accept edge; later changes have no effect.
- Arithmetic wraps modulo 2^W. c_out is the carry out of bit W-1.
- W=4 degenerates to a single RUN cycle.
- rst_n=0 in any state (including mid-RUN or DONE with out_ready=0) aborts the operation. All registers return to reset values on that edge, and no result is emitted.
- Simultaneous in_valid and rst_n=0: reset wins and the operand is not accepted.

Test Plan:
- add, a=0x1234, b=0x4321, c_in=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, c_out=0, ovf=0.
- add, a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
- sub, a=0x0005, b=0x0007, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0. Also sub a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Backpressure: out_ready=0 for 3 cycles in DONE -> sum/c_out/ovf/out_valid held constant; in_valid=1 with new operands during RUN/DONE is not accepted (in_ready=0). After out_ready=1 the next op is accepted in IDLE and yields a correct result.
- Reset: assert rst_n=0 for one edge at cnt=2 of a RUN -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0. A following op a=0x0F0F, b=0x00F1, c_in=1 -> sum=0x1001, c_out=0.
- W=4 instance: add a=0x9, b=0x8, c_in=1 -> out_valid 1 cycle after accept; sum=0x2, c_out=1, ovf=1.
